ikari_sprite_line_buffer: RTL and testbench

- Double-buffered sprite line buffer that produces the 8-bit sprite pixel stream (L1D) consumed by the final video colour mixer.
- During line N the sprite renderer writes pixels into the "write bank" by X coordinate, while the "read bank" is scanned out at pixel rate.
- Each scanned location is cleared to transparent right after it is read.
- Banks swap on every line start.

---
 rtl/ikari_video_pkg.sv | 15 +
 rtl/ikari_sprite_line_buffer_if.sv | 27 ++
 rtl/lbuf_bank_ram.sv | 23 ++
 rtl/ikari_sprite_line_buffer.sv | 116 +++++++++++
 tb/tb_ikari_sprite_line_buffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ikari_video_pkg.sv
// rtl/ikari_video_pkg.sv - shared sprite video constants, line-buffer state type and pixel helpers
package ikari_video_pkg;

  localparam logic [7:0] TRANSP_PIX = 8'h7F;
  localparam int         SPR_AW     = 9;
  localparam int         SPR_DW     = 8;

  typedef enum logic {LB_CLEAR, LB_RUN} lb_state_t;

  // Low nibble 4'hF marks a transparent pixel regardless of colour bank.
  function automatic logic is_transp(input logic [SPR_DW-1:0] pix);
    return pix[3:0] == 4'hF;
  endfunction

endpackage

// File: rtl/ikari_sprite_line_buffer_if.sv
// rtl/ikari_sprite_line_buffer_if.sv - renderer/mixer-facing signals of the sprite line buffer
interface ikari_sprite_line_buffer_if
  import ikari_video_pkg::*;
#(
  parameter int AW = SPR_AW,
  parameter int DW = SPR_DW
);

  logic          line_start;
  logic          cen_px;
  logic          wr_en;
  logic [AW-1:0] wr_x;
  logic [DW-1:0] wr_pix;
  logic          busy;
  logic [DW-1:0] LD;

  modport master (
    output line_start, cen_px, wr_en, wr_x, wr_pix,
    input  busy, LD
  );

  modport slave (
    input  line_start, cen_px, wr_en, wr_x, wr_pix,
    output busy, LD
  );

endinterface

// File: rtl/lbuf_bank_ram.sv
// rtl/lbuf_bank_ram.sv - one line-buffer bank: simple dual-port RAM, 1-clk sync read, no reset
module lbuf_bank_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ikari_sprite_line_buffer.sv
// rtl/ikari_sprite_line_buffer.sv - double-buffered sprite line buffer with clear-after-read scanout
module ikari_sprite_line_buffer
  import ikari_video_pkg::*;
#(
  parameter int            AW     = SPR_AW,
  parameter int            DW     = SPR_DW,
  parameter logic [DW-1:0] TRANSP = DW'(TRANSP_PIX),
  parameter logic [AW-1:0] RD_X0  = '0
) (
  input logic                       clk,
  input logic                       rst,
  ikari_sprite_line_buffer_if.slave lb
);

  lb_state_t     state;
  logic          bank_sel;
  logic [AW-1:0] rd_x;
  logic [AW-1:0] clr_addr;
  logic          rd_pend;
  logic [AW-1:0] rd_addr_q;
  logic          rd_bank_q;
  logic [DW-1:0] ld_q;
  logic          busy_q;

  logic          rd_fire;
  logic          wr_hit;
  logic          ram_we    [2];
  logic [AW-1:0] ram_waddr [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  // A cen_px coinciding with line_start is swallowed by the rd_x restart.
  assign rd_fire = (state == LB_RUN) && lb.cen_px && !lb.line_start;
  assign wr_hit  = (state == LB_RUN) && lb.wr_en && !is_transp(lb.wr_pix);

  // Writer owns bank_sel, clear-after-read owns the bank latched at read time;
  // if a swap lands between the two, the fresh pixel takes priority.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_we[b]    = 1'b0;
      ram_waddr[b] = clr_addr;
      ram_wdata[b] = TRANSP;
      if (state == LB_CLEAR) begin
        ram_we[b] = 1'b1;
      end else if (wr_hit && (bank_sel == b[0])) begin
        ram_we[b]    = 1'b1;
        ram_waddr[b] = lb.wr_x;
        ram_wdata[b] = lb.wr_pix;
      end else if (rd_pend && (rd_bank_q == b[0])) begin
        ram_we[b]    = 1'b1;
        ram_waddr[b] = rd_addr_q;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    lbuf_bank_ram #(
      .AW(AW),
      .DW(DW)
    ) u_ram (
      .clk  (clk),
      .we   (ram_we[g]),
      .waddr(ram_waddr[g]),
      .wdata(ram_wdata[g]),
      .raddr(rd_x),
      .rdata(ram_rdata[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LB_CLEAR;
      bank_sel  <= 1'b0;
      clr_addr  <= '0;
      rd_x      <= RD_X0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      ld_q      <= TRANSP;
      busy_q    <= 1'b1;
    end else begin
      if (lb.line_start) begin
        bank_sel <= ~bank_sel;
      end
      rd_pend <= rd_fire;
      if (rd_fire) begin
        rd_addr_q <= rd_x;
        rd_bank_q <= ~bank_sel;
      end
      case (state)
        LB_CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == '1) begin
            state  <= LB_RUN;
            busy_q <= 1'b0;
          end
        end
        LB_RUN: begin
          if (lb.line_start) begin
            rd_x <= RD_X0;
          end else if (lb.cen_px) begin
            rd_x <= rd_x + AW'(1);
          end
          if (rd_pend) begin
            ld_q <= ram_rdata[rd_bank_q];
          end
        end
        default: state <= LB_CLEAR;
      endcase
    end
  end

  assign lb.busy = busy_q;
  assign lb.LD   = ld_q;

endmodule

// File: tb/tb_ikari_sprite_line_buffer.sv
// tb/tb_ikari_sprite_line_buffer.sv - directed scoreboard bench for the sprite line buffer
module tb_ikari_sprite_line_buffer;
  import ikari_video_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ikari_sprite_line_buffer_if lb ();

  ikari_sprite_line_buffer dut (
    .clk(clk),
    .rst(rst),
    .lb (lb)
  );

  logic [7:0] mem [2][512];
  bit         bsel;
  int         rdx;
  int         clr_left;
  bit         prev_read;
  logic [7:0] last_ld;
  logic [7:0] sb_q [$];
  logic [7:0] seen_q [$];
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [7:0] exp_basic [10] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                                 8'h23, 8'h7F, 8'h7F, 8'h7F, 8'h7F};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) mem[b][a] = 8'h7F;
    bsel      = 1'b0;
    rdx       = 0;
    clr_left  = 512;
    prev_read = 1'b0;
    last_ld   = 8'h7F;
    sb_q.delete();
  endtask

  // One clock: drive inputs, advance the model for that edge, then check outputs.
  task automatic tick(input bit ls, input bit cen, input bit we, input int x, input logic [7:0] pix);
    bit rd;
    logic [7:0] e;
    lb.line_start = ls;
    lb.cen_px     = cen;
    lb.wr_en      = we;
    lb.wr_x       = 9'(x);
    lb.wr_pix     = pix;
    rd = 1'b0;
    if (clr_left == 0) begin
      if (cen && !ls) begin
        sb_q.push_back(mem[!bsel][rdx]);
        mem[!bsel][rdx] = 8'h7F;
        rdx = (rdx + 1) % 512;
        rd = 1'b1;
      end
      if (we && pix[3:0] != 4'hF) mem[bsel][x] = pix;
      if (ls) rdx = 0;
    end else begin
      clr_left--;
    end
    if (ls) bsel = !bsel;
    @(posedge clk);
    #1;
    lb.line_start = 1'b0;
    lb.cen_px     = 1'b0;
    lb.wr_en      = 1'b0;
    if (prev_read) begin
      check("sb_level", 16'(sb_q.size() != 0), 16'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        last_ld = e;
        check("ld_read", 16'(lb.LD), 16'(e));
        seen_q.push_back(lb.LD);
      end
    end else begin
      check("ld_hold", 16'(lb.LD), 16'(last_ld));
    end
    check("busy", 16'(lb.busy), 16'(clr_left != 0));
    prev_read = rd;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_ld", 16'(lb.LD), 16'h007F);
    check("rst_busy", 16'(lb.busy), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int ls_at);
    int cnt = 0;
    while (lb.busy === 1'b1 && cnt < 600) begin
      tick(cnt == ls_at, 1'b0, 1'b0, 0, 8'h00);
      cnt++;
    end
    check("busy_clks", 16'(cnt), 16'd512);
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 0, 8'h00);
  endtask

  task automatic scan_all();
    int dirty = 0;
    seen_q.delete();
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(512);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(512);
    foreach (seen_q[i]) if (seen_q[i] !== 8'h7F) dirty++;
    check("scan_all_cnt", 16'(seen_q.size()), 16'd1024);
    check("scan_all_transp", 16'(dirty), 16'd0);
  endtask

  initial begin
    lb.line_start = 1'b0;
    lb.cen_px     = 1'b0;
    lb.wr_en      = 1'b0;
    lb.wr_x       = '0;
    lb.wr_pix     = '0;
    apply_reset();
    wait_ready(-1);
    scan_all();

    // basic line
    seen_q.delete();
    tick(1'b0, 1'b0, 1'b1, 5, 8'h23);
    tick(1'b0, 1'b0, 1'b1, 6, 8'h4F);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(10);
    check("basic_cnt", 16'(seen_q.size()), 16'd10);
    for (int i = 0; i < 10 && i < seen_q.size(); i++) check("basic_seq", 16'(seen_q[i]), 16'(exp_basic[i]));

    // clear-after-read
    seen_q.delete();
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(10);
    check("clr_after_read", 16'(seen_q[5]), 16'h007F);

    // overwrite and transparent-over-opaque
    seen_q.delete();
    tick(1'b0, 1'b0, 1'b1, 10, 8'h12);
    tick(1'b0, 1'b0, 1'b1, 10, 8'h34);
    tick(1'b0, 1'b0, 1'b1, 11, 8'h12);
    tick(1'b0, 1'b0, 1'b1, 11, 8'h3F);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(12);
    check("overwrite", 16'(seen_q[10]), 16'h0034);
    check("transp_keep", 16'(seen_q[11]), 16'h0012);

    // line_start + write + cen_px in one clk
    seen_q.delete();
    tick(1'b1, 1'b1, 1'b1, 3, 8'h55);
    tick(1'b0, 1'b0, 1'b0, 0, 8'h00);
    check("collide_no_read", 16'(seen_q.size()), 16'd0);
    scan(5);
    check("collide_cnt", 16'(seen_q.size()), 16'd5);
    check("collide_x0", 16'(seen_q[0]), 16'h007F);
    check("collide_x3", 16'(seen_q[3]), 16'h0055);

    // mid-line reset
    tick(1'b0, 1'b0, 1'b1, 99, 8'h2A);
    tick(1'b0, 1'b0, 1'b1, 200, 8'h61);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 50, 8'h19);
    scan(100);
    check("pre_reset_ld", 16'(lb.LD), 16'h002A);
    apply_reset();
    wait_ready(5);
    seen_q.delete();
    tick(1'b0, 1'b0, 1'b1, 7, 8'h66);
    tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    scan(8);
    check("clear_swap_x7", 16'(seen_q[7]), 16'h0066);
    scan_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
